gshare_pht_ctrl: RTL and testbench
==================================

Name: gshare_pht_ctrl

Overview:
- Controller directly upstream of the 256-entry, 2-bit-counter pattern history table (PHT).
- Fetch side: hashes fetch PC with speculative global history, drives the PHT read index, turns the returned counter into a taken/not-taken prediction.
- Resolve side: computes the saturating counter update, registers the PHT write, recovers history on mispredict.
- After reset, walks the whole PHT to re-initialise every counter to weakly-not-taken (2'b01).

Parameters:
HIST_LEN, 8, global history length in bits; legal 1..8; history is zero-extended to 8 bits for hashing.
INIT_VAL, 2'b01, counter value written to every PHT entry during init.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_valid  in  1  fetch stage presents a PC this cycle
fetch_is_br  in  1  fetched instruction is a conditional branch
fetch_pc  in  32  fetch PC
ready  out  1  1 = predictor operational (RUN state)
pred_taken  out  1  prediction for fetch_pc (combinational)
pred_index  out  8  PHT index used; carried down the pipeline
pred_counter  out  2  effective counter used; carried down the pipeline
pred_ghr  out  HIST_LEN  speculative history snapshot; carried down the pipeline
pht_rindex  out  8  to PHT read index
pht_rdata  in  2  from PHT read data (asynchronous read)
pht_write  out  1  to PHT write enable
pht_windex  out  8  to PHT write index
pht_wdata  out  2  to PHT write data
resolve_valid  in  1  a conditional branch resolves this cycle
resolve_taken  in  1  actual outcome
resolve_mispredict  in  1  prediction was wrong
resolve_index  in  8  pred_index carried with the branch
resolve_counter  in  2  pred_counter carried with the branch
resolve_ghr  in  HIST_LEN  pred_ghr carried with the branch

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- States: INIT, RUN.
- rst=1 at a clock edge has these effects:
  - state<=INIT, init_cnt<=0, spec_ghr<=0, pending write cleared.
  - Outputs while in reset or INIT: ready=0, pred_taken=0, pred_counter=0, pred_ghr=0.
  - Reset mid-RUN or mid-INIT restarts INIT from entry 0.
- INIT:
  - Each cycle: pht_write=1, pht_windex=init_cnt, pht_wdata=INIT_VAL, init_cnt++.
  - Entries 0..255 are written in 256 cycles; the edge that writes entry 255 moves the state to RUN.
  - fetch and resolve inputs are ignored; no history update.
- RUN, fetch path (combinational):
  - idx = fetch_pc[9:2] XOR zext(spec_ghr); pht_rindex=idx; pred_index=idx.
  - eff = (wr_pend && wr_idx==idx) ? wr_data : pht_rdata. This forwards the write landing this edge.
  - pred_counter=eff; pred_taken=eff[1]; pred_ghr=spec_ghr.
- RUN, history update:
  - Mispredict recovery: if resolve_valid && resolve_mispredict, spec_ghr<={resolve_ghr[HIST_LEN-2:0], resolve_taken}. For HIST_LEN=1, spec_ghr<=resolve_taken. Recovery has priority over a same-cycle fetch.
  - Otherwise, if fetch_valid && fetch_is_br, spec_ghr<={spec_ghr[HIST_LEN-2:0], pred_taken}.
- RUN, counter update (1-cycle registered):
  - On resolve_valid: base = (wr_pend && wr_idx==resolve_index) ? wr_data : resolve_counter. This covers back-to-back resolves to one entry.
  - new = resolve_taken ? sat_inc(base) : sat_dec(base). Saturation: 2'b11 stays 2'b11 on inc; 2'b00 stays 2'b00 on dec.
  - Next edge: wr_pend<=1, wr_idx<=resolve_index, wr_data<=new. With no resolve, wr_pend<=0.
  - pht_write=wr_pend, pht_windex=wr_idx, pht_wdata=wr_data. The PHT commits one cycle after the write is registered.
- Resolve without mispredict still updates the counter, but never touches spec_ghr.

Optional Feature:
GSHARE_HASH_EN
- Defined: index = fetch_pc[9:2] XOR history, exactly as above.
- Undefined: bimodal mode.
  - Index = fetch_pc[9:2] only.
  - spec_ghr is held at 0 and pred_ghr=0; resolve_ghr is ignored.
  - All other behaviour is unchanged.

Test Plan:
1. Init sweep: pulse rst, then release. Expect exactly 256 cycles of pht_write=1 with windex 0..255 and wdata=2'b01, and ready=0 during them. ready=1 on the following cycle.
2. Saturation: resolve idx 0x10, taken, counter 2'b01, repeated 4x back-to-back. Expect PHT writes 2'b10, 2'b11, 2'b11, 2'b11. Then 4 not-taken resolves write 2'b10, 2'b01, 2'b00, 2'b00.
3. Forwarding: resolve idx 0x22 taken (counter 2'b01). Next cycle fetch a PC hashing to 0x22. Expect pred_counter=2'b10 and pred_taken=1, even though pht_rdata=2'b01.
4. History/hash (GSHARE_HASH_EN, HIST_LEN=8): from reset, fetch 3 branches all predicted taken. Expect spec_ghr=0x07; fetch_pc=0x100 then gives pht_rindex=0x40^0x07=0x47.
5. Recovery: with spec_ghr=0x07, resolve_mispredict with resolve_ghr=0x02, resolve_taken=0, plus a simultaneous fetch branch. Expect spec_ghr=0x04; the fetch shift is dropped.
6. Reset mid-operation: assert rst during RUN with a pending write. Expect no stale pht_write, ready=0, spec_ghr=0, and a full 256-cycle re-init sweep.

Source files
------------

// File: rtl/gshare_pht_if.sv
// Bundle of fetch, prediction, PHT and resolve signals between the pipeline/PHT
// and the gshare controller; dbg_state mirrors the controller FSM (1 = RUN).
interface gshare_pht_if #(
  parameter int HIST_LEN = 8
);
  logic                fetch_valid;
  logic                fetch_is_br;
  logic [31:0]         fetch_pc;
  logic                ready;
  logic                pred_taken;
  logic [7:0]          pred_index;
  logic [1:0]          pred_counter;
  logic [HIST_LEN-1:0] pred_ghr;
  logic [7:0]          pht_rindex;
  logic [1:0]          pht_rdata;
  logic                pht_write;
  logic [7:0]          pht_windex;
  logic [1:0]          pht_wdata;
  logic                resolve_valid;
  logic                resolve_taken;
  logic                resolve_mispredict;
  logic [7:0]          resolve_index;
  logic [1:0]          resolve_counter;
  logic [HIST_LEN-1:0] resolve_ghr;
  logic                dbg_state;

  modport master (
    output fetch_valid, fetch_is_br, fetch_pc, pht_rdata,
    output resolve_valid, resolve_taken, resolve_mispredict,
    output resolve_index, resolve_counter, resolve_ghr,
    input  ready, pred_taken, pred_index, pred_counter, pred_ghr,
    input  pht_rindex, pht_write, pht_windex, pht_wdata, dbg_state
  );

  modport slave (
    input  fetch_valid, fetch_is_br, fetch_pc, pht_rdata,
    input  resolve_valid, resolve_taken, resolve_mispredict,
    input  resolve_index, resolve_counter, resolve_ghr,
    output ready, pred_taken, pred_index, pred_counter, pred_ghr,
    output pht_rindex, pht_write, pht_windex, pht_wdata, dbg_state
  );
endinterface

// File: rtl/gshare_pht_ctrl.sv
// Gshare/bimodal controller for a 256-entry 2-bit PHT: init sweep, prediction,
// registered counter update and history recovery. GSHARE_HASH_EN enables history hashing.
module gshare_pht_ctrl #(
  parameter int         HIST_LEN = 8,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  gshare_pht_if.slave bus
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state, state_nx;
  logic [7:0]          init_cnt;
  logic [HIST_LEN-1:0] spec_ghr, ghr_nx;
  logic                wr_pend;
  logic [7:0]          wr_idx;
  logic [1:0]          wr_data;
  logic [7:0]          idx;
  logic [1:0]          eff;
  logic [1:0]          base;
  logic [1:0]          upd;
  logic                run;
`ifdef GSHARE_HASH_EN
  logic [7:0]          hist8;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == S_INIT && init_cnt == 8'hFF) state_nx = S_RUN;
  end

  always_comb begin
`ifdef GSHARE_HASH_EN
    hist8 = '0;
    hist8[HIST_LEN-1:0] = spec_ghr;
    idx = bus.fetch_pc[9:2] ^ hist8;
`else
    idx = bus.fetch_pc[9:2];
`endif
    // Forward the write that commits at the coming edge; the PHT still holds the old value.
    eff  = (wr_pend && wr_idx == idx) ? wr_data : bus.pht_rdata;
    base = (wr_pend && wr_idx == bus.resolve_index) ? wr_data : bus.resolve_counter;
    if (bus.resolve_taken) upd = (base == 2'b11) ? 2'b11 : base + 2'd1;
    else                   upd = (base == 2'b00) ? 2'b00 : base - 2'd1;
`ifdef GSHARE_HASH_EN
    ghr_nx = spec_ghr;
    if (bus.resolve_valid && bus.resolve_mispredict)
      ghr_nx = (bus.resolve_ghr << 1) | HIST_LEN'(bus.resolve_taken);
    else if (bus.fetch_valid && bus.fetch_is_br)
      ghr_nx = (spec_ghr << 1) | HIST_LEN'(eff[1]);
`else
    ghr_nx = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= 8'd0;
      spec_ghr <= '0;
      wr_pend  <= 1'b0;
      wr_idx   <= 8'd0;
      wr_data  <= 2'b00;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 8'd1;
      wr_pend  <= 1'b0;
    end else begin
      spec_ghr <= ghr_nx;
      wr_pend  <= bus.resolve_valid;
      if (bus.resolve_valid) begin
        wr_idx  <= bus.resolve_index;
        wr_data <= upd;
      end
    end
  end

  assign run              = (state == S_RUN) && !rst;
  assign bus.ready        = run;
  assign bus.dbg_state    = (state == S_RUN);
  assign bus.pht_rindex   = idx;
  assign bus.pred_index   = idx;
  assign bus.pred_counter = run ? eff : 2'b00;
  assign bus.pred_taken   = run & eff[1];
  assign bus.pred_ghr     = run ? spec_ghr : '0;

  // A write held over from before reset must never reach the PHT.
  assign bus.pht_write  = !rst && ((state == S_INIT) || wr_pend);
  assign bus.pht_windex = (state == S_INIT) ? init_cnt : wr_idx;
  assign bus.pht_wdata  = (state == S_INIT) ? INIT_VAL : wr_data;

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Directed bench for gshare_pht_ctrl: init sweep, saturation, forwarding,
// history hashing, mispredict recovery and reset during operation.
module tb_gshare_pht_ctrl;
  localparam int HL = 8;
`ifdef GSHARE_HASH_EN
  localparam bit HASH = 1'b1;
`else
  localparam bit HASH = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gshare_pht_if #(.HIST_LEN(HL)) bus ();

  gshare_pht_ctrl #(.HIST_LEN(HL), .INIT_VAL(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_valid        = 1'b0;
    bus.fetch_is_br        = 1'b0;
    bus.fetch_pc           = 32'h0;
    bus.pht_rdata          = 2'b00;
    bus.resolve_valid      = 1'b0;
    bus.resolve_taken      = 1'b0;
    bus.resolve_mispredict = 1'b0;
    bus.resolve_index      = 8'h00;
    bus.resolve_counter    = 2'b00;
    bus.resolve_ghr        = '0;
  endtask

  // Entered just after the edge that left reset; returns in the first RUN cycle.
  task automatic run_init_sweep(input bit noisy);
    for (int i = 0; i < 256; i++) begin
      if (noisy) begin
        bus.fetch_valid        = 1'b1;
        bus.fetch_is_br        = 1'b1;
        bus.fetch_pc           = $urandom_range(0, 1023);
        bus.pht_rdata          = 2'b11;
        bus.resolve_valid      = 1'b1;
        bus.resolve_taken      = 1'b1;
        bus.resolve_mispredict = 1'b1;
        bus.resolve_index      = 8'($urandom_range(0, 255));
        bus.resolve_counter    = 2'b10;
        bus.resolve_ghr        = '1;
      end
      @(negedge clk);
      checks++;
      if (bus.pht_write !== 1'b1 || bus.pht_windex !== 8'(i) || bus.pht_wdata !== 2'b01) begin
        errors++;
        $display("FAIL init_write[%0d]: got we=%b idx=%0h data=%b required we=1 idx=%0h data=01",
                 i, bus.pht_write, bus.pht_windex, bus.pht_wdata, i);
      end
      checks++;
      if (bus.ready !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_ghr !== '0) begin
        errors++;
        $display("FAIL init_outputs[%0d]: got ready=%b taken=%b ghr=%0h required 0 0 0",
                 i, bus.ready, bus.pred_taken, bus.pred_ghr);
      end
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.pht_write !== 1'b0 || bus.pred_ghr !== '0) begin
      errors++;
      $display("FAIL init_done: got ready=%b we=%b ghr=%0h required ready=1 we=0 ghr=0",
               bus.ready, bus.pht_write, bus.pred_ghr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || bus.pht_write !== 1'b0 || bus.pred_counter !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b we=%b cnt=%b required 0 0 00",
               bus.ready, bus.pht_write, bus.pred_counter);
    end
    cyc();
    rst = 1'b0;
    run_init_sweep(1'b0);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [8];
    exp_sat = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    cyc();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        bus.resolve_valid   = 1'b1;
        bus.resolve_index   = 8'h10;
        bus.resolve_counter = 2'b01;
        bus.resolve_taken   = (k < 4);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (bus.pht_write !== 1'b1 || bus.pht_windex !== 8'h10 || bus.pht_wdata !== exp_sat[k-1]) begin
          errors++;
          $display("FAIL sat_write[%0d]: got we=%b idx=%0h data=%b required we=1 idx=10 data=%b",
                   k - 1, bus.pht_write, bus.pht_windex, bus.pht_wdata, exp_sat[k-1]);
        end
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (bus.pht_write !== 1'b0) begin
      errors++;
      $display("FAIL sat_drain: got we=%b required 0", bus.pht_write);
    end
  endtask

  task automatic test_forwarding();
    cyc();
    bus.resolve_valid   = 1'b1;
    bus.resolve_index   = 8'h22;
    bus.resolve_counter = 2'b01;
    bus.resolve_taken   = 1'b1;
    cyc();
    idle_inputs();
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h0000_0088;
    bus.pht_rdata   = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.pred_counter !== 2'b10 || bus.pred_taken !== 1'b1 || bus.pht_rindex !== 8'h22) begin
      errors++;
      $display("FAIL fwd_pred: got cnt=%b taken=%b ridx=%0h required cnt=10 taken=1 ridx=22",
               bus.pred_counter, bus.pred_taken, bus.pht_rindex);
    end
    checks++;
    if (bus.pht_write !== 1'b1 || bus.pht_windex !== 8'h22 || bus.pht_wdata !== 2'b10) begin
      errors++;
      $display("FAIL fwd_write: got we=%b idx=%0h data=%b required we=1 idx=22 data=10",
               bus.pht_write, bus.pht_windex, bus.pht_wdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.pred_counter !== 2'b01 || bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL fwd_after: got cnt=%b taken=%b required cnt=01 taken=0",
               bus.pred_counter, bus.pred_taken);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_history_hash();
    logic [HL-1:0] exp_g [3];
    logic [7:0]    exp_idx;
    exp_g   = HASH ? '{8'h01, 8'h03, 8'h07} : '{8'h00, 8'h00, 8'h00};
    exp_idx = HASH ? 8'h47 : 8'h40;
    cyc();
    for (int k = 0; k < 3; k++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_is_br = 1'b1;
      bus.fetch_pc    = 32'h0;
      bus.pht_rdata   = 2'b10;
      @(negedge clk);
      checks++;
      if (bus.pred_taken !== 1'b1) begin
        errors++;
        $display("FAIL hist_pred[%0d]: got taken=%b required 1", k, bus.pred_taken);
      end
      cyc();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.pred_ghr !== exp_g[k]) begin
        errors++;
        $display("FAIL hist_ghr[%0d]: got %0h required %0h", k, bus.pred_ghr, exp_g[k]);
      end
    end
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if (bus.pht_rindex !== exp_idx || bus.pred_index !== exp_idx) begin
      errors++;
      $display("FAIL hist_index: got ridx=%0h pidx=%0h required %0h",
               bus.pht_rindex, bus.pred_index, exp_idx);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_recovery();
    logic [HL-1:0] exp_rec;
    logic [HL-1:0] exp_shift;
    exp_rec   = HASH ? 8'h04 : 8'h00;
    exp_shift = HASH ? 8'h08 : 8'h00;
    bus.resolve_valid      = 1'b1;
    bus.resolve_mispredict = 1'b1;
    bus.resolve_taken      = 1'b0;
    bus.resolve_ghr        = 8'h02;
    bus.resolve_index      = 8'h30;
    bus.resolve_counter    = 2'b01;
    bus.fetch_valid        = 1'b1;
    bus.fetch_is_br        = 1'b1;
    bus.pht_rdata          = 2'b10;
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.pred_ghr !== exp_rec) begin
      errors++;
      $display("FAIL recover_ghr: got %0h required %0h", bus.pred_ghr, exp_rec);
    end
    checks++;
    if (bus.pht_write !== 1'b1 || bus.pht_windex !== 8'h30 || bus.pht_wdata !== 2'b00) begin
      errors++;
      $display("FAIL recover_write: got we=%b idx=%0h data=%b required we=1 idx=30 data=00",
               bus.pht_write, bus.pht_windex, bus.pht_wdata);
    end
    bus.resolve_valid   = 1'b1;
    bus.resolve_taken   = 1'b1;
    bus.resolve_ghr     = 8'hFF;
    bus.resolve_index   = 8'h31;
    bus.resolve_counter = 2'b10;
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.pred_ghr !== exp_rec || bus.pht_wdata !== 2'b11) begin
      errors++;
      $display("FAIL resolve_no_mp: got ghr=%0h data=%b required ghr=%0h data=11",
               bus.pred_ghr, bus.pht_wdata, exp_rec);
    end
    bus.fetch_valid = 1'b1;
    bus.fetch_is_br = 1'b1;
    bus.pht_rdata   = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL nt_pred: got taken=%b required 0", bus.pred_taken);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.pred_ghr !== exp_shift) begin
      errors++;
      $display("FAIL nt_shift: got %0h required %0h", bus.pred_ghr, exp_shift);
    end
  endtask

  task automatic test_reset_mid_run();
    cyc();
    bus.resolve_valid   = 1'b1;
    bus.resolve_index   = 8'h55;
    bus.resolve_counter = 2'b01;
    bus.resolve_taken   = 1'b1;
    cyc();
    idle_inputs();
    bus.fetch_valid = 1'b1;
    bus.pht_rdata   = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pht_write !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_write: got we=%b ready=%b required 0 0", bus.pht_write, bus.ready);
    end
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_counter !== 2'b00 || bus.pred_ghr !== '0) begin
      errors++;
      $display("FAIL midrst_pred: got taken=%b cnt=%b ghr=%0h required 0 00 0",
               bus.pred_taken, bus.pred_counter, bus.pred_ghr);
    end
    cyc();
    rst = 1'b0;
    idle_inputs();
    run_init_sweep(1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_saturation();
    test_forwarding();
    test_history_hash();
    test_recovery();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
